hazard_ctrl: RTL

- Pipeline sequencer for the 5-stage MIPS core.
- Drives the PC write enable, the IF/ID write and flush controls, and the ID/EX Flush input (bubble insertion).
- Resolves load-use stalls, taken-branch and jump squashes, data-memory busy freezes, and a multi-cycle interrupt-entry sequence.
- Keeps a saturating stall-cycle counter.
- Sits beside the ID stage. Sees ID register addresses, EX-stage control, and the external busy and interrupt lines.

---
 rtl/cpu_ctrl_pkg.sv | 12 +
 rtl/hazard_detect.sv | 16 +
 rtl/hazard_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared control-path encodings for the 5-stage MIPS core.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ENTER = 2'd2
    } state_t;

    localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use compare between the ID instruction and a load in EX.
module hazard_detect (
    input  logic       mem_read_i,
    input  logic [4:0] write_addr_i,
    input  logic [4:0] rs_addr_i,
    input  logic [4:0] rt_addr_i,
    input  logic       uses_rs_i,
    input  logic       uses_rt_i,
    output logic       load_use_o
);

    assign load_use_o = mem_read_i && write_addr_i != 5'd0 &&
                        ((uses_rs_i && rs_addr_i == write_addr_i) ||
                         (uses_rt_i && rt_addr_i == write_addr_i));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for stalls, squashes, memory freezes and interrupt entry.
module hazard_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           ID_rs_addr,
    input  logic [4:0]           ID_rt_addr,
    input  logic                 ID_uses_rs,
    input  logic                 ID_uses_rt,
    input  logic                 ID_jump,
    input  logic                 EX_MemRead,
    input  logic [4:0]           EX_write_addr,
    input  logic                 EX_branch_taken,
    input  logic                 mem_busy,
    input  logic                 irq,
    output logic                 PC_write,
    output logic                 IF_ID_write,
    output logic                 IF_ID_flush,
    output logic                 ID_EX_flush,
    output logic                 PC_sel_exc,
    output logic                 epc_capture,
    output logic                 irq_ack,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    state_t               state_q, state_d;
    logic [2:0]           drain_q, drain_d;
    logic                 irq_prev_q, irq_pending_q;
    logic [CNT_WIDTH-1:0] stall_count_q;
    logic                 load_use;

    hazard_detect u_detect (
        .mem_read_i  (EX_MemRead),
        .write_addr_i(EX_write_addr),
        .rs_addr_i   (ID_rs_addr),
        .rt_addr_i   (ID_rt_addr),
        .uses_rs_i   (ID_uses_rs),
        .uses_rt_i   (ID_uses_rt),
        .load_use_o  (load_use)
    );

    always_comb begin
        PC_write    = 1'b1;
        IF_ID_write = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        PC_sel_exc  = 1'b0;
        epc_capture = 1'b0;
        irq_ack     = 1'b0;
        state_d     = state_q;
        drain_d     = drain_q;
        if (reset) begin
            PC_write    = 1'b0;
            IF_ID_write = 1'b0;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (mem_busy) begin
                        PC_write    = 1'b0;
                        IF_ID_write = 1'b0;
                    end else if (EX_branch_taken) begin
                        IF_ID_flush = 1'b1;
                        ID_EX_flush = 1'b1;
                    end else if (load_use) begin
                        PC_write    = 1'b0;
                        IF_ID_write = 1'b0;
                        ID_EX_flush = 1'b1;
                    end else if (irq_pending_q) begin
                        PC_write    = 1'b0;
                        IF_ID_flush = 1'b1;
                        ID_EX_flush = 1'b1;
                        epc_capture = 1'b1;
                        drain_d     = DRAIN_LOAD;
                        state_d     = ST_DRAIN;
                    end else if (ID_jump) begin
                        IF_ID_flush = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // EX sees only bubbles here, so a taken branch cannot occur and is ignored
                    PC_write = 1'b0;
                    if (mem_busy) begin
                        IF_ID_write = 1'b0;
                    end else begin
                        IF_ID_flush = 1'b1;
                        ID_EX_flush = 1'b1;
                        state_d     = drain_q == 3'd0 ? ST_ENTER : ST_DRAIN;
                        drain_d     = drain_q == 3'd0 ? drain_q : drain_q - 3'd1;
                    end
                end
                ST_ENTER: begin
                    if (mem_busy) begin
                        PC_write = 1'b0;
                    end else begin
                        PC_sel_exc  = 1'b1;
                        IF_ID_flush = 1'b1;
                        irq_ack     = 1'b1;
                        state_d     = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            drain_q       <= 3'd0;
            irq_prev_q    <= 1'b0;
            irq_pending_q <= 1'b0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            drain_q       <= drain_d;
            irq_prev_q    <= irq;
            // a new edge in the ack cycle must survive the clear
            irq_pending_q <= (irq && !irq_prev_q) || (irq_pending_q && !irq_ack);
            stall_count_q <= (!PC_write && stall_count_q != '1) ? stall_count_q + CNT_WIDTH'(1) : stall_count_q;
        end
    end

    assign stall_count = stall_count_q;

endmodule
